bpu_update_scheduler: RTL and testbench

- In-order tracker for in-flight conditional branches between fetch-time prediction and execute-time resolution.
- Holds each branch's PC bits and the global-history snapshot used at prediction.
- Records outcomes as branches resolve, out of order, and retires them in program order.
- Retirement drives exactly one single-cycle update into the gshare predictor (update_en, pc_bits_write, history_write, outcome); on a mispredict, squashes younger entries.

---
 rtl/bpu_update_scheduler_if.sv | 44 ++++
 rtl/bpu_update_scheduler.sv | 111 +++++++++++
 tb/tb_bpu_update_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_scheduler_if.sv
// Bundles the fetch-side alloc channel, execute-side resolve channel and
// predictor update/status outputs of the branch update scheduler.
interface bpu_update_scheduler_if #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = $clog2(DEPTH)
);
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [HISTORY_LEN-1:0] alloc_pc_bits;
  logic [HISTORY_LEN-1:0] alloc_history;
  logic [TAG_W-1:0]       alloc_tag;

  logic                   resolve_valid;
  logic [TAG_W-1:0]       resolve_tag;
  logic                   resolve_outcome;
  logic                   resolve_mispredict;

  logic                   upd_en;
  logic [HISTORY_LEN-1:0] upd_pc_bits;
  logic [HISTORY_LEN-1:0] upd_history;
  logic                   upd_outcome;

  logic [TAG_W:0]         occupancy;
  logic                   empty;
  logic                   full;
  logic                   resolve_err;

  modport master (
    output alloc_valid, alloc_pc_bits, alloc_history,
    output resolve_valid, resolve_tag, resolve_outcome, resolve_mispredict,
    input  alloc_ready, alloc_tag,
    input  upd_en, upd_pc_bits, upd_history, upd_outcome,
    input  occupancy, empty, full, resolve_err
  );

  modport slave (
    input  alloc_valid, alloc_pc_bits, alloc_history,
    input  resolve_valid, resolve_tag, resolve_outcome, resolve_mispredict,
    output alloc_ready, alloc_tag,
    output upd_en, upd_pc_bits, upd_history, upd_outcome,
    output occupancy, empty, full, resolve_err
  );
endinterface

// File: rtl/bpu_update_scheduler.sv
// In-order tracker for in-flight branches: resolves out of order, retires in
// program order with one predictor update per retire, squashes on mispredict.
module bpu_update_scheduler #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  bpu_update_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    E_FREE,
    E_PENDING,
    E_RESOLVED
  } entry_state_e;

  entry_state_e           st [DEPTH];
  logic [HISTORY_LEN-1:0] pc_mem   [DEPTH];
  logic [HISTORY_LEN-1:0] hist_mem [DEPTH];
  logic                   out_mem  [DEPTH];

  logic [TAG_W-1:0]       head, tail;
  logic [TAG_W:0]         count;

  logic                   upd_en_q, upd_outcome_q, err_q;
  logic [HISTORY_LEN-1:0] upd_pc_q, upd_hist_q;

  logic                   alloc_ready, alloc_fire, resolve_ok, squash, retire;
  logic [TAG_W-1:0]       rel_rt;
  logic [TAG_W:0]         squash_cnt;
  logic                   squash_mask [DEPTH];

  // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
  always_comb begin
    alloc_ready = (count != (TAG_W+1)'(DEPTH)) &&
                  !(bus.resolve_valid && bus.resolve_mispredict);
    alloc_fire  = bus.alloc_valid && alloc_ready;
    resolve_ok  = bus.resolve_valid && (st[bus.resolve_tag] == E_PENDING);
    squash      = resolve_ok && bus.resolve_mispredict;
    retire      = (st[head] == E_RESOLVED);
    rel_rt      = bus.resolve_tag - head;
    squash_cnt  = '0;
    if (squash)
      squash_cnt = count - (TAG_W+1)'(rel_rt) - (TAG_W+1)'(1);
    // Age relative to head decides which entries are younger than the mispredict.
    for (int i = 0; i < DEPTH; i++)
      squash_mask[i] = squash && ((TAG_W'(i) - head) > rel_rt);
  end

  // NOTE: entry payload storage has no reset; validity is carried only by st[].
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_mem[tail]   <= bus.alloc_pc_bits;
      hist_mem[tail] <= bus.alloc_history;
    end
    if (resolve_ok)
      out_mem[bus.resolve_tag] <= bus.resolve_outcome;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        st[i] <= E_FREE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      upd_en_q      <= 1'b0;
      upd_pc_q      <= '0;
      upd_hist_q    <= '0;
      upd_outcome_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash_mask[i])
          st[i] <= E_FREE;
      // Head is never younger than the resolved entry, so retire and squash never collide.
      if (retire) begin
        st[head]      <= E_FREE;
        upd_pc_q      <= pc_mem[head];
        upd_hist_q    <= hist_mem[head];
        upd_outcome_q <= out_mem[head];
      end
      if (resolve_ok)
        st[bus.resolve_tag] <= E_RESOLVED;
      if (alloc_fire)
        st[tail] <= E_PENDING;

      upd_en_q <= retire;
      head     <= head + TAG_W'(retire);
      tail     <= squash ? bus.resolve_tag + TAG_W'(1) : tail + TAG_W'(alloc_fire);
      count    <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire) - squash_cnt;
      if (bus.resolve_valid && !resolve_ok)
        err_q <= 1'b1;
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail;
  assign bus.upd_en      = upd_en_q;
  assign bus.upd_pc_bits = upd_pc_q;
  assign bus.upd_history = upd_hist_q;
  assign bus.upd_outcome = upd_outcome_q;
  assign bus.occupancy   = count;
  assign bus.empty       = (count == '0);
  assign bus.full        = (count == (TAG_W+1)'(DEPTH));
  assign bus.resolve_err = err_q;

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// program-order queue model of in-flight branches.
module tb_bpu_update_scheduler;
  localparam int HL = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpu_update_scheduler_if #(.HISTORY_LEN(HL), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  bpu_update_scheduler #(.HISTORY_LEN(HL), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [HL-1:0]    pc;
    logic [HL-1:0]    hist;
    bit               resolved;
    bit               outcome;
  } rec_t;

  rec_t             q[$];
  logic [TAG_W-1:0] m_tail;
  bit               m_err, m_upd_en, m_out;
  logic [HL-1:0]    m_pc, m_hist;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    q.delete();
    m_tail = '0; m_err = 0; m_upd_en = 0; m_out = 0; m_pc = '0; m_hist = '0;
  endtask

  task automatic check_status();
    check("upd_en",      bus.upd_en,      m_upd_en);
    check("upd_pc_bits", bus.upd_pc_bits, m_pc);
    check("upd_history", bus.upd_history, m_hist);
    check("upd_outcome", bus.upd_outcome, m_out);
    check("occupancy",   bus.occupancy,   q.size());
    check("empty",       bus.empty,       q.size() == 0);
    check("full",        bus.full,        q.size() == DEPTH);
    check("resolve_err", bus.resolve_err, m_err);
  endtask

  // One clock cycle: drive after the falling edge, check combinational
  // outputs, advance the model, then check registered outputs after the rise.
  task automatic step(input bit av, input logic [HL-1:0] pc, input logic [HL-1:0] hist,
                      input bit rv, input logic [TAG_W-1:0] rt, input bit ro, input bit rm);
    bit   exp_ready, do_retire;
    rec_t ret;
    int   idx;
    bus.alloc_valid = av; bus.alloc_pc_bits = pc; bus.alloc_history = hist;
    bus.resolve_valid = rv; bus.resolve_tag = rt;
    bus.resolve_outcome = ro; bus.resolve_mispredict = rm;
    #1;
    exp_ready = (q.size() < DEPTH) && !(rv && rm);
    check("alloc_ready", bus.alloc_ready, exp_ready);
    if (av && exp_ready) check("alloc_tag", bus.alloc_tag, m_tail);

    do_retire = (q.size() > 0) && q[0].resolved;
    if (do_retire) ret = q[0];
    if (rv) begin
      idx = -1;
      foreach (q[i]) if (q[i].tag == rt) idx = i;
      if (idx < 0 || q[idx].resolved) m_err = 1;
      else begin
        q[idx].resolved = 1;
        q[idx].outcome  = ro;
        if (rm) begin
          while (q.size() > idx + 1) void'(q.pop_back());
          m_tail = rt + 1'b1;
        end
      end
    end
    if (av && exp_ready) begin
      q.push_back('{tag: m_tail, pc: pc, hist: hist, resolved: 0, outcome: 0});
      m_tail = m_tail + 1'b1;
    end
    m_upd_en = do_retire;
    if (do_retire) begin
      void'(q.pop_front());
      m_pc = ret.pc; m_hist = ret.hist; m_out = ret.outcome;
    end

    @(posedge clk); #1;
    if (bus.upd_en) n_pulses++;
    check_status();
    @(negedge clk);
    bus.alloc_valid = 0; bus.resolve_valid = 0; bus.resolve_mispredict = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic alloc(input logic [HL-1:0] pc, input logic [HL-1:0] hist);
    step(1, pc, hist, 0, '0, 0, 0);
  endtask

  task automatic resolve(input logic [TAG_W-1:0] rt, input bit ro, input bit rm);
    step(0, '0, '0, 1, rt, ro, rm);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_empty",     bus.empty,     1);
    check("rst_alloc_tag", bus.alloc_tag, 0);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int p0;
  logic [TAG_W-1:0] rt;

  initial begin
    bus.alloc_valid = 0; bus.alloc_pc_bits = '0; bus.alloc_history = '0;
    bus.resolve_valid = 0; bus.resolve_tag = '0;
    bus.resolve_outcome = 0; bus.resolve_mispredict = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Fill to full, fifth alloc refused.
    alloc(8'h11, 8'hA0); alloc(8'h22, 8'hA1); alloc(8'h33, 8'hA2); alloc(8'h44, 8'hA3);
    check("full_after_4", bus.full, 1);
    alloc(8'h55, 8'hA4);
    check("fifth_refused_occ", bus.occupancy, 4);

    // Out-of-order resolve, in-order retire.
    p0 = n_pulses;
    resolve(2, 1, 0); resolve(0, 0, 0); resolve(1, 1, 0);
    idle(4);
    check("three_pulses", n_pulses - p0, 3);
    check("occ_after_retire", bus.occupancy, 1);

    // Mispredict with simultaneous alloc attempt.
    do_reset();
    alloc(8'h01, 8'hB0); alloc(8'h02, 8'hB1); alloc(8'h03, 8'hB2); alloc(8'h04, 8'hB3);
    step(1, 8'h99, 8'h99, 1, 2'd1, 1, 1);
    check("squash_occ", bus.occupancy, 2);
    alloc(8'h05, 8'hB4);

    // Error cases: FREE tag, then already-RESOLVED tag.
    p0 = n_pulses;
    resolve(3, 0, 1);
    check("err_free", bus.resolve_err, 1);
    resolve(1, 0, 0);
    check("err_resolved", bus.resolve_err, 1);
    check("err_no_pulse", n_pulses - p0, 0);
    check("err_occ", bus.occupancy, 3);

    // Wrap-around: continuous alloc and retire of 6 branches.
    do_reset();
    p0 = n_pulses;
    for (int k = 0; k < 10; k++) begin
      step(k < 6, 8'h60 + 8'(k), 8'hC0 + 8'(k),
           (k >= 1 && k <= 6), 2'(k - 1), k[0], 0);
    end
    check("wrap_pulses", n_pulses - p0, 6);

    // Reset while three entries are pending.
    alloc(8'h71, 8'hD0); alloc(8'h72, 8'hD1); alloc(8'h73, 8'hD2);
    p0 = n_pulses;
    do_reset();
    idle(3);
    check("no_pulse_after_reset", n_pulses - p0, 0);
    alloc(8'h74, 8'hD3);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      if (q.size() > 0 && ($urandom % 4) != 0) rt = q[$urandom % q.size()].tag;
      else rt = TAG_W'($urandom);
      step(($urandom % 3) != 0, HL'($urandom), HL'($urandom),
           ($urandom % 2) == 0, rt, 1'($urandom), ($urandom % 8) == 0);
      if ((k % 150) == 149) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
